// File: rtl/uart_baud_nco_pkg.sv
// Shared constants and the phase-increment helper for the fractional-N
// UART baud generator and its benches.
package uart_baud_nco_pkg;

   localparam int unsigned DEF_CLOCK_RATE = 42_000_000;
   localparam int unsigned DEF_BAUD_RATE  = 115_200;
   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned DEF_ACC_W      = 24;

   // Rounded phase increment: (baud*os*2^w + clk/2) / clk in 64-bit math.
   function automatic longint unsigned uart_inc(
      input longint unsigned clk_hz,
      input longint unsigned baud_hz,
      input longint unsigned os,
      input int unsigned     acc_w
   );
      return (baud_hz * os * (64'd1 << acc_w) + clk_hz / 64'd2) / clk_hz;
   endfunction

endpackage

// File: rtl/uart_baud_nco_acc.sv
// Phase accumulator with a registered carry strobe. The carry flop is high
// for one clock after each accumulator wrap; clear or disable zeroes both.
module uart_nco_acc #(
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clear,
   input  logic [ACC_W-1:0] i_inc,
   output logic             o_carry
);

   logic [ACC_W-1:0] r_acc;
   logic             r_carry;

   // Accumulate the increment each enabled clock; capture the wrap as carry.
   // NOTE: every flop uses non-blocking (<=) so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
      end else if (!i_en || i_clear) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
      end else begin
         {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, i_inc};
      end
   end

   assign o_carry = r_carry;

endmodule

// File: rtl/uart_baud_nco.sv
// Fractional-N baud generator: rx_tick at BAUD*OVERSAMPLE, tx_tick at BAUD.
// Optional runtime increment register enabled by `define UART_BAUD_NCO_CFG_EN;
// without it cfg_inc/cfg_load are accepted but ignored.
module uart_baud_nco
   import uart_baud_nco_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = DEF_CLOCK_RATE,
   parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned ACC_W      = DEF_ACC_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [ACC_W-1:0]              cfg_inc,
   input  logic                          cfg_load,
   output logic                          rx_tick,
   output logic                          tx_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

   localparam int unsigned       OS_W        = $clog2(OVERSAMPLE);
   localparam longint unsigned   INC_DEFAULT = uart_inc(64'(CLOCK_RATE), 64'(BAUD_RATE),
                                                        64'(OVERSAMPLE), ACC_W);
   localparam logic [OS_W-1:0]   OS_LAST     = OS_W'(OVERSAMPLE - 1);

   // An increment of zero never ticks; one of 2^ACC_W or more cannot be held.
   if ((INC_DEFAULT == 64'd0) || (INC_DEFAULT >= (64'd1 << ACC_W))) begin : g_inc_range
      $error("uart_baud_nco: INC_DEFAULT out of range for ACC_W");
   end

   logic [ACC_W-1:0] w_inc;
   logic             w_clear;
   logic             w_carry;
   logic             r_rx_tick;
   logic             r_tx_tick;
   logic [OS_W-1:0]  r_os_phase;

`ifdef UART_BAUD_NCO_CFG_EN
   logic [ACC_W-1:0] r_inc;

   // Runtime increment: reset to the default, replaced on each cfg_load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inc <= ACC_W'(INC_DEFAULT);
      end else if (cfg_load) begin
         r_inc <= cfg_inc;
      end
   end

   assign w_inc   = r_inc;
   assign w_clear = cfg_load;
`else
   logic w_cfg_unused;

   assign w_inc        = ACC_W'(INC_DEFAULT);
   assign w_clear      = 1'b0;
   assign w_cfg_unused = ^{cfg_inc, cfg_load};
`endif

   uart_nco_acc #(
      .ACC_W (ACC_W)
   ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (en),
      .i_clear (w_clear),
      .i_inc   (w_inc),
      .o_carry (w_carry)
   );

   // Register the tick strobes and advance the oversample index on each rx_tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_tick  <= 1'b0;
         r_tx_tick  <= 1'b0;
         r_os_phase <= '0;
      end else if (!en || w_clear) begin
         r_rx_tick  <= 1'b0;
         r_tx_tick  <= 1'b0;
         r_os_phase <= '0;
      end else begin
         r_rx_tick <= w_carry;
         r_tx_tick <= w_carry && (r_os_phase == OS_LAST);
         if (w_carry) begin
            r_os_phase <= (r_os_phase == OS_LAST) ? '0 : r_os_phase + OS_W'(1);
         end
      end
   end

   assign rx_tick  = r_rx_tick;
   assign tx_tick  = r_tx_tick;
   assign os_phase = r_os_phase;

endmodule

// File: tb/tb_uart_baud_nco.sv
// Directed bench for uart_baud_nco (default parameters). Sections that
// exercise the runtime increment only build with UART_BAUD_NCO_CFG_EN.
module tb_uart_baud_nco;

   localparam int     ACC_W = 24;
   localparam int     OS    = 16;
   // (115200*16*2^24 + 21e6) / 42e6 = 736280.6 -> 736280
   localparam longint INC   = 64'd736280;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [ACC_W-1:0] cfg_inc;
   logic             cfg_load;
   logic             rx_tick;
   logic             tx_tick;
   logic [3:0]       os_phase;

   int     n_tests = 0;
   int     n_fail  = 0;
   longint k_model = 0;   // enabled edges since the accumulator last started from 0

   uart_baud_nco dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .cfg_inc  (cfg_inc),
      .cfg_load (cfg_load),
      .rx_tick  (rx_tick),
      .tx_tick  (tx_tick),
      .os_phase (os_phase)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Accumulator wraps at enabled edge k when floor(k*inc/2^W) steps.
   function automatic bit wrap_at(input longint k, input longint inc);
      return ((k * inc) >> ACC_W) != (((k - 1) * inc) >> ACC_W);
   endfunction

   task automatic first_tick(output int edges);
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         k_model++;
         if (rx_tick === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   // Sample m edges; compare against the accumulator model and the phase model.
   task automatic run_window(input int m, input int start_phase,
                             output int rx_n, output int tx_n, output int bad_gap,
                             output int bad_tx, output int bad_phase, output int bad_model);
      int  last;
      int  phase;
      bit  exp_rx;
      last  = -1;
      phase = start_phase;
      rx_n = 0; tx_n = 0; bad_gap = 0; bad_tx = 0; bad_phase = 0; bad_model = 0;
      for (int i = 1; i <= m; i++) begin
         @(posedge clk); #1;
         k_model++;
         exp_rx = (k_model >= 2) && wrap_at(k_model - 1, INC);
         if ((rx_tick === 1'b1) != exp_rx) bad_model++;
         if (rx_tick === 1'b1) begin
            rx_n++;
            phase = (phase + 1) % OS;
            if (last >= 0 && ((i - last) < 22 || (i - last) > 23)) bad_gap++;
            last = i;
            if (tx_tick !== (phase == 0)) bad_tx++;
            if (tx_tick === 1'b1) tx_n++;
         end else if (tx_tick !== 1'b0) begin
            bad_tx++;
         end
         if (os_phase !== 4'(phase)) bad_phase++;
      end
   endtask

   initial begin
      int edges;
      int rx_n, tx_n, bad_gap, bad_tx, bad_phase, bad_model;
      int bad_idle;
      bit found;
      longint rx_exp;

      rst_n    = 1'b1;
      en       = 1'b0;
      cfg_inc  = '0;
      cfg_load = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      // Reset state, before any clock edge
      check("reset_rx_tick", rx_tick, 0);
      check("reset_tx_tick", tx_tick, 0);
      check("reset_os_phase", os_phase, 0);
      check("reset_inc", dut.w_inc, INC);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_rx_tick", rx_tick, 0);
      check("idle_os_phase", os_phase, 0);

`ifndef UART_BAUD_NCO_CFG_EN
      // cfg_load must be ignored in the default build
      cfg_inc  = 24'h400000;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      check("cfg_ignored_inc", dut.w_inc, INC);
`endif

      // First tick: ceil(2^24/736280)+1 = 24 edges after enable
      en      = 1'b1;
      k_model = 0;
      first_tick(edges);
      check("first_tick_edges", edges, 24);
      check("first_tick_os_phase", os_phase, 1);
      check("first_tick_no_tx", tx_tick, 0);

      // Long run from k=24, os_phase=1
      run_window(20000, 1, rx_n, tx_n, bad_gap, bad_tx, bad_phase, bad_model);
      rx_exp = (((24 + 20000) - 1) * INC >> ACC_W) - ((23 * INC) >> ACC_W);
      check("run_rx_count", rx_n, rx_exp);
      check("run_tx_count", tx_n, (rx_exp + 1) / OS);
      check("run_gap_22_23", bad_gap, 0);
      check("run_tx_decode", bad_tx, 0);
      check("run_os_phase", bad_phase, 0);
      check("run_tick_timing", bad_model, 0);

      // Drop en exactly when a carry is pending: the next tick must be suppressed
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         k_model++;
         if (wrap_at(k_model, INC)) begin
            found = 1'b1;
            break;
         end
      end
      check("carry_pending_found", found, 1);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      check("en_low_rx_gated", rx_tick, 0);
      check("en_low_tx_gated", tx_tick, 0);
      check("en_low_os_phase", os_phase, 0);
      bad_idle = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || os_phase !== 4'd0) bad_idle++;
      end
      check("en_low_quiet", bad_idle, 0);
      @(negedge clk);
      en      = 1'b1;
      k_model = 0;
      first_tick(edges);
      check("reenable_first_tick", edges, 24);
      check("reenable_os_phase", os_phase, 1);

      // Async reset while rx_tick and tx_tick are both high
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (tx_tick === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("tx_tick_reached", found, 1);
      check("tx_with_rx", rx_tick, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_rx", rx_tick, 0);
      check("async_rst_tx", tx_tick, 0);
      check("async_rst_os_phase", os_phase, 0);
      #2 rst_n = 1'b1;
      k_model = 0;
      first_tick(edges);
      check("post_reset_first_tick", edges, 24);
      check("post_reset_inc", dut.w_inc, INC);

`ifdef UART_BAUD_NCO_CFG_EN
      // inc = 2^22: wrap every 4 edges; first rx at edge 5 after the load edge
      @(negedge clk);
      cfg_inc  = 24'h400000;
      cfg_load = 1'b1;
      @(posedge clk); #1;
      check("cfg_load_forces_rx0", rx_tick, 0);
      check("cfg_load_os_phase", os_phase, 0);
      @(negedge clk);
      cfg_load = 1'b0;
      rx_n = 0; tx_n = 0; bad_gap = 0; edges = -1;
      for (int i = 1; i <= 256; i++) begin
         @(posedge clk); #1;
         if (rx_tick === 1'b1) begin
            if (edges >= 0 && (i - edges) != 4) bad_gap++;
            edges = i;
            rx_n++;
         end
         if (tx_tick === 1'b1) tx_n++;
      end
      check("cfg_fast_rx_count", rx_n, 63);
      check("cfg_fast_tx_count", tx_n, 3);
      check("cfg_fast_gap4", bad_gap, 0);

      @(negedge clk);
      cfg_inc  = '0;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      rx_n = 0;
      repeat (10000) begin
         @(posedge clk); #1;
         if (rx_tick !== 1'b0 || tx_tick !== 1'b0) rx_n++;
      end
      check("cfg_zero_no_ticks", rx_n, 0);
      check("cfg_zero_acc", dut.u_acc.r_acc, 0);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("cfg_reset_inc", dut.w_inc, INC);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
